// File: rtl/gf180mcu_fd_sc_mcu9t5v0__demux4_deser.sv
// gf180mcu_fd_sc_mcu9t5v0__demux4_deser: 1:4 deserializer rebuilding four lanes from a rotating beat stream
module gf180mcu_fd_sc_mcu9t5v0__demux4_deser #(
  parameter int WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic [WIDTH-1:0] I,
  input  logic             I_VALID,
  output logic             I_READY,
  input  logic             SYNC,
  output logic [WIDTH-1:0] Z0,
  output logic [WIDTH-1:0] Z1,
  output logic [WIDTH-1:0] Z2,
  output logic [WIDTH-1:0] Z3,
  output logic             Z_VALID,
  input  logic             Z_READY,
  output logic [1:0]       S
);
  logic [1:0]            s_q, s_d;
  logic [2:0][WIDTH-1:0] l_q, l_d;
  logic [3:0][WIDTH-1:0] z_q, z_d;
  logic                  z_valid_q, z_valid_d;
  logic                  acc, load;
  assign I_READY = (s_q != 2'd3) | ~z_valid_q | Z_READY;
  assign S       = s_q;
  assign Z_VALID = z_valid_q;
  assign Z0      = z_q[0];
  assign Z1      = z_q[1];
  assign Z2      = z_q[2];
  assign Z3      = z_q[3];
  // Steer accepted beats into staging lanes; the fourth beat loads the whole word at once
  always_comb begin
    acc       = I_VALID & I_READY;
    load      = acc & ~SYNC & (s_q == 2'd3);
    s_d       = SYNC ? {1'b0, acc} : acc ? s_q + 2'd1 : s_q;
    l_d       = l_q;
    for (int k = 0; k < 3; k++)
      if (acc & (SYNC ? (k == 0) : (s_q == 2'(k)))) l_d[k] = I;
    z_d       = load ? {I, l_q} : z_q;
    z_valid_d = load | (z_valid_q & ~Z_READY);
  end
  // State registers, cleared asynchronously so a mid-word reset drops everything at once
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      s_q       <= '0;
      l_q       <= '0;
      z_q       <= '0;
      z_valid_q <= 1'b0;
    end else begin
      s_q       <= s_d;
      l_q       <= l_d;
      z_q       <= z_d;
      z_valid_q <= z_valid_d;
    end
  end
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__demux4_deser.sv
// tb_gf180mcu_fd_sc_mcu9t5v0__demux4_deser: directed and random checks against a queue-based beat grouping model
module tb_gf180mcu_fd_sc_mcu9t5v0__demux4_deser;
  localparam int W = 8;
  logic         CLK = 1'b0;
  logic         RN;
  logic [W-1:0] I;
  logic         I_VALID, SYNC, Z_READY;
  logic         I_READY, Z_VALID;
  logic [W-1:0] Z0, Z1, Z2, Z3;
  logic [1:0]   S;
  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0]   part[$];
  logic [W-1:0]   src[$];
  bit             pend;
  bit             sb_on = 0;
  int             n_acc = 0;
  logic [4*W-1:0] zw;

  gf180mcu_fd_sc_mcu9t5v0__demux4_deser #(.WIDTH(W)) dut (
    .CLK(CLK), .RN(RN), .I(I), .I_VALID(I_VALID), .I_READY(I_READY), .SYNC(SYNC),
    .Z0(Z0), .Z1(Z1), .Z2(Z2), .Z3(Z3), .Z_VALID(Z_VALID), .Z_READY(Z_READY), .S(S)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [4*W-1:0] obs, input logic [4*W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    part.delete();
    pend = 0;
    zw   = '0;
  endtask

  task automatic step(input bit iv, input logic [W-1:0] d, input bit sy, input bit zr);
    bit rdy, acc, load;
    logic [4*W-1:0] w;
    I_VALID = iv; I = d; SYNC = sy; Z_READY = zr;
    @(negedge CLK);
    rdy = (part.size() != 3) || !pend || zr;
    chk("s", 32'(S), 32'(part.size()));
    chk("z_valid", 32'(Z_VALID), 32'(pend));
    chk("i_ready", 32'(I_READY), 32'(rdy));
    chk("z", {Z3, Z2, Z1, Z0}, zw);
    acc = iv && rdy;
    if (sb_on && pend && zr) begin
      chk("sb_avail", 32'(src.size() >= 4), 32'd1);
      if (src.size() >= 4) begin
        w = {src[3], src[2], src[1], src[0]};
        repeat (4) void'(src.pop_front());
        chk("sb_word", {Z3, Z2, Z1, Z0}, w);
      end
    end
    if (acc) n_acc++;
    if (sb_on && acc) src.push_back(d);
    load = 0;
    if (acc && sy) begin
      part.delete();
      part.push_back(d);
    end else if (acc) begin
      part.push_back(d);
      if (part.size() == 4) begin
        zw = {part[3], part[2], part[1], part[0]};
        part.delete();
        load = 1;
      end
    end else if (sy) part.delete();
    pend = load || (pend && !zr);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int start;
    RN = 0; I = '0; I_VALID = 0; SYNC = 0; Z_READY = 0;
    mreset();
    #2;
    chk("rst_s", 32'(S), 32'd0);
    chk("rst_z_valid", 32'(Z_VALID), 32'd0);
    chk("rst_z", {Z3, Z2, Z1, Z0}, '0);
    repeat (2) @(posedge CLK);
    #1;
    RN = 1;
    // single word A,B,C,D with a ready consumer
    step(1, 8'hA, 0, 1); step(1, 8'hB, 0, 1); step(1, 8'hC, 0, 1); step(1, 8'hD, 0, 1);
    step(0, 8'h0, 0, 1); step(0, 8'h0, 0, 1);
    // back-to-back beats 1..8
    for (int i = 1; i <= 8; i++) step(1, W'(i), 0, 1);
    step(0, 8'h0, 0, 1);
    // backpressure: word pending, lane 3 stalls until Z_READY pulses
    for (int i = 1; i <= 7; i++) step(1, W'(i), 0, 0);
    step(1, 8'h8, 0, 0); step(1, 8'h8, 0, 0);
    step(1, 8'h8, 0, 1);
    step(0, 'x, 0, 0);
    step(0, 8'h0, 0, 1);
    // SYNC with a beat realigns to lane 0
    step(1, 8'h1, 0, 1); step(1, 8'h2, 0, 1); step(1, 8'h9, 1, 1);
    step(1, 8'hA, 0, 1); step(1, 8'hB, 0, 1); step(1, 8'hC, 0, 1);
    step(0, 8'h0, 0, 1);
    // SYNC alone drops a partial word and keeps a pending one
    step(1, 8'h11, 0, 1); step(1, 8'h22, 0, 1); step(1, 8'h33, 0, 1); step(1, 8'h44, 0, 0);
    step(1, 8'h55, 0, 0); step(0, 8'h0, 1, 0);
    step(1, 8'h66, 0, 0); step(1, 8'h77, 0, 0); step(1, 8'h88, 0, 0); step(1, 8'h99, 0, 1);
    step(0, 8'h0, 0, 1);
    // asynchronous reset mid-word with a pending word
    for (int i = 1; i <= 6; i++) step(1, W'(8'h40 + i), 0, 0);
    RN = 0;
    #1;
    chk("arst_s", 32'(S), 32'd0);
    chk("arst_z_valid", 32'(Z_VALID), 32'd0);
    chk("arst_z", {Z3, Z2, Z1, Z0}, '0);
    mreset();
    @(posedge CLK);
    #1;
    RN = 1;
    step(0, 8'h0, 0, 1);
    // random traffic against the in-order grouping scoreboard
    sb_on = 1;
    start = n_acc;
    for (int c = 0; c < 40000 && (n_acc - start) < 10000; c++)
      step(($urandom % 4) != 0, W'($urandom), 0, ($urandom % 2) != 0);
    chk("rand_beats", 32'(n_acc - start), 32'd10000);
    repeat (3) step(0, 8'h0, 0, 1);
    chk("sb_left", 32'(src.size()), 32'(part.size()));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
